// File: rtl/rvfi_imem_arbiter_if.sv
// Bundle of both requester fetch ports and the shared instruction-memory port.
// The arbiter connects through the slave modport and the requester/memory side through master.
interface rvfi_imem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              r0_req;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [31:0]       r0_rdata;
  logic              r1_req;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [31:0]       r1_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              timeout_err;

  modport slave (
    input  r0_req, r0_addr, r1_req, r1_addr, mem_gnt, mem_rvalid, mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    output mem_req, mem_addr, timeout_err
  );

  modport master (
    output r0_req, r0_addr, r1_req, r1_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    input  mem_req, mem_addr, timeout_err
  );
endinterface

// File: rtl/rvfi_imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between two requesters, one transaction in flight.
// Define RVFI_IMEM_ARBITER_TIMEOUT_EN to build the ISSUE/WAIT timeout counter and sticky timeout_err.
module rvfi_imem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset,
  rvfi_imem_arbiter_if.slave bus
);

  // IDLE: arbitrate, grant combinationally | ISSUE: mem_req held until mem_gnt | WAIT: awaiting mem_rvalid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              last_q;
  logic              owner_q;
  logic              sel;
  logic              grant;
  logic              resp;
  logic              timeout_hit;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              r0_rvalid_q, r1_rvalid_q;
  logic [31:0]       r0_rdata_q, r1_rdata_q;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("rvfi_imem_arbiter: TIMEOUT must be at least 1");
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    resp    = 1'b0;
    if (bus.r0_req && bus.r1_req) sel = ~last_q;
    else                          sel = bus.r1_req;
    case (state_q)
      IDLE: begin
        if ((bus.r0_req || bus.r1_req) && !reset) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: if (bus.mem_gnt) state_d = WAIT;
      WAIT: begin
        if (bus.mem_rvalid) begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      addr_q      <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= (state_d == ISSUE);
      r0_rvalid_q <= resp && !owner_q;
      r1_rvalid_q <= resp && owner_q;
      if (grant) begin
        last_q  <= sel;
        owner_q <= sel;
        addr_q  <= sel ? bus.r1_addr : bus.r0_addr;
      end
      if (resp && !owner_q) r0_rdata_q <= bus.mem_rdata;
      if (resp && owner_q)  r1_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.r0_gnt    = grant & ~sel;
  assign bus.r1_gnt    = grant & sel;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_rdata  = r1_rdata_q;

`ifdef RVFI_IMEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // A response arriving on the last allowed WAIT cycle still completes normally.
  assign timeout_hit = ((state_q == ISSUE) || ((state_q == WAIT) && !bus.mem_rvalid))
                       && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant)                 cnt_q <= '0;
      else if (state_q != IDLE)  cnt_q <= cnt_q + 1'b1;
      if (timeout_hit)           err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/rvfi_imem_arbiter.md
RVFI_IMEM_ARBITER -- requirements
Module: rvfi_imem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all fetch addresses.
REQ-002 Parameter: TIMEOUT, default 15, maximum cycles a transaction may spend in ISSUE plus WAIT (used only under REQ-030).
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 r0_req  input  1  requester 0 fetch request; held with stable r0_addr until r0_gnt.
REQ-006 r0_addr  input  ADDR_W  requester 0 fetch address.
REQ-007 r0_gnt  output  1  combinational one-cycle acceptance of requester 0 request.
REQ-008 r0_rvalid  output  1  registered one-cycle response strobe to requester 0.
REQ-009 r0_rdata  output  32  response data to requester 0, valid when r0_rvalid.
REQ-010 r1_req, r1_addr, r1_gnt, r1_rvalid, r1_rdata: same directions, widths and meanings as REQ-005..009, for requester 1.
REQ-011 mem_req  output  1  registered request to the shared instruction memory.
REQ-012 mem_addr  output  ADDR_W  registered address, stable while mem_req=1.
REQ-013 mem_gnt  input  1  memory accepts request when mem_req=1 and mem_gnt=1.
REQ-014 mem_rvalid  input  1  memory response strobe.
REQ-015 mem_rdata  input  32  memory response data.
REQ-016 timeout_err  output  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; exactly one memory transaction outstanding at any time.
REQ-018 IDLE: if any rN_req=1, the selected requester's gnt=1 in the same cycle, its address and owner id are latched, and next state is ISSUE with mem_req=1 from the next cycle.
REQ-019 Both req=1 in IDLE: grant the requester not granted last (round-robin); single req: grant it regardless of pointer.
REQ-020 Last-grant pointer updates only when a gnt is issued.
REQ-021 rN_gnt is 0 in ISSUE and WAIT regardless of rN_req.
REQ-022 ISSUE: mem_req=1, mem_addr=latched address; on mem_gnt=1, mem_req drops next cycle and next state is WAIT.
REQ-023 mem_rvalid is ignored in IDLE and ISSUE.
REQ-024 WAIT: on mem_rvalid=1, owner's rvalid=1 and rdata=mem_rdata in the following cycle for exactly one cycle; next state IDLE.
REQ-025 Non-owner rvalid stays 0; rdata of a requester holds its last value when rvalid=0.
REQ-026 A new gnt may issue in the same cycle the previous response's rvalid is asserted; minimum gnt-to-gnt spacing is 3 cycles (mem_gnt and mem_rvalid each on first opportunity).
REQ-027 Latency: gnt at cycle t, mem_req at t+1; mem_gnt at t+1 and mem_rvalid at t+2 give rvalid at t+3.

Reset
REQ-028 Reset: state IDLE, mem_req=0, mem_addr=0, r0/r1 rvalid=0, r0/r1 rdata=0, timeout_err=0, last-grant pointer = requester 1 (requester 0 wins first contention); gnt outputs are 0 while reset=1.
REQ-029 Reset mid-transaction abandons it; no rvalid is produced for it, and a later stray mem_rvalid in IDLE is ignored per REQ-023.

Configuration
REQ-030 Macro RVFI_IMEM_ARBITER_TIMEOUT_EN defined: a counter clears on entry to ISSUE, increments each cycle in ISSUE/WAIT; when it reaches TIMEOUT, timeout_err sets (sticky until reset), the FSM returns to IDLE, mem_req drops, and the owner gets no response.
REQ-031 Macro not defined: no counter is built, timeout_err is tied 0, and a transaction may wait indefinitely.

Verification
REQ-032 Single fetch: r0_req=1, r0_addr=0x100, mem_gnt=1 at t+1, mem_rvalid=1 with rdata=0x00000013 at t+2 -> r0_gnt at t, mem_addr=0x100 at t+1, r0_rvalid=1 and r0_rdata=0x00000013 at t+3, r1_rvalid=0.
REQ-033 Contention after reset: r0_req and r1_req both held at 1 -> grants in order r0, r1, r0, r1, with each requester's rvalid paired to its own address 0x200 or 0x300.
REQ-034 Memory stall: mem_gnt held 0 for 5 cycles -> mem_req and mem_addr stable all 5 cycles, no rN_gnt issued, response routed correctly afterwards.
REQ-035 Early rvalid: mem_rvalid=1 during ISSUE -> ignored; only the mem_rvalid in WAIT produces rvalid.
REQ-036 Reset in WAIT, then mem_rvalid=1 one cycle after reset deasserts -> no rvalid on either requester; state IDLE.
REQ-037 With RVFI_IMEM_ARBITER_TIMEOUT_EN and TIMEOUT=15, mem_gnt never asserted -> timeout_err=1 after 15 cycles in ISSUE, FSM back in IDLE, next r1_req granted.
